// File: rtl/fdivsqrt_sequencer.sv
// Control sequencer for an iterative FP divide / square-root datapath.
// Steps each operation through pre-normalization, iteration, rounding or special-result paths.
module fdivsqrt_sequencer #(
   parameter int unsigned NITER = 14
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       StartE,
   input  logic       OpType,
   input  logic [2:0] Ztype,
   input  logic       InvalidIn,
   input  logic       DenormIn,
   input  logic       FlushE,
   output logic       Busy,
   output logic       LoadOperands,
   output logic       NormEn,
   output logic       IterEn,
   output logic [4:0] IterCount,
   output logic       RoundEn,
   output logic [2:0] SpecialSel,
   output logic       OpTypeQ,
   output logic       ResultValid,
   output logic       InvalidFlag,
   output logic       DivZeroFlag
);

   localparam logic [4:0] LastIter = 5'(NITER - 1);
   localparam logic [2:0] ZNormal  = 3'b000;
   localparam logic [2:0] ZDivZero = 3'b110;

   typedef enum logic [2:0] {StIdle, StNorm, StIter, StRound, StSpecial, StDone} state_e;

   state_e state_q;
   logic   accept;

   // Acceptance is only possible in IDLE; flush and reset both veto it.
   assign accept       = (state_q == StIdle) & StartE & ~FlushE & ~reset;
   assign LoadOperands = accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         IterCount   <= 5'd0;
         SpecialSel  <= 3'b000;
         OpTypeQ     <= 1'b0;
         InvalidFlag <= 1'b0;
         DivZeroFlag <= 1'b0;
      end else if (FlushE) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (StartE) begin
                  SpecialSel  <= Ztype;
                  OpTypeQ     <= OpType;
                  InvalidFlag <= InvalidIn;
                  DivZeroFlag <= (Ztype == ZDivZero) & ~OpType;
                  IterCount   <= 5'd0;
                  if ((Ztype != ZNormal) || InvalidIn) begin
                     state_q <= StSpecial;
                  end else if (DenormIn) begin
                     state_q <= StNorm;
                  end else begin
                     state_q <= StIter;
                  end
               end
            end
            StNorm:    state_q <= StIter;
            StIter: begin
               IterCount <= IterCount + 5'd1;
               if (IterCount == LastIter) begin
                  state_q <= StRound;
               end
            end
            StRound:   state_q <= StDone;
            StSpecial: state_q <= StDone;
            StDone:    state_q <= StIdle;
            default:   state_q <= StIdle;
         endcase
      end
   end

   // Strobes decode directly from the state register, so they are glitch-free and exclusive.
   assign Busy        = (state_q != StIdle);
   assign NormEn      = (state_q == StNorm);
   assign IterEn      = (state_q == StIter);
   assign RoundEn     = (state_q == StRound);
   assign ResultValid = (state_q == StDone);

endmodule

// File: tb/tb_fdivsqrt_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model
// that predicts every output from the cycle offset since the accepted request.
module tb_fdivsqrt_sequencer;

   localparam int unsigned NITER = 14;

   logic       clk = 1'b0;
   logic       reset, StartE, OpType, InvalidIn, DenormIn, FlushE;
   logic [2:0] Ztype;
   logic       Busy, LoadOperands, NormEn, IterEn, RoundEn, OpTypeQ, ResultValid;
   logic       InvalidFlag, DivZeroFlag;
   logic [4:0] IterCount;
   logic [2:0] SpecialSel;

   fdivsqrt_sequencer #(.NITER(NITER)) dut (
      .clk(clk), .reset(reset), .StartE(StartE), .OpType(OpType), .Ztype(Ztype),
      .InvalidIn(InvalidIn), .DenormIn(DenormIn), .FlushE(FlushE), .Busy(Busy),
      .LoadOperands(LoadOperands), .NormEn(NormEn), .IterEn(IterEn), .IterCount(IterCount),
      .RoundEn(RoundEn), .SpecialSel(SpecialSel), .OpTypeQ(OpTypeQ),
      .ResultValid(ResultValid), .InvalidFlag(InvalidFlag), .DivZeroFlag(DivZeroFlag)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: an operation is a timeline indexed by m_k = cycles since the accepting edge.
   bit         m_init   = 0;
   bit         m_active = 0;
   bit         m_clean  = 0;   // IterCount known to be 0 while idle (after reset, before accept)
   int         m_kind   = 0;   // 0 normal, 1 denormal, 2 special
   int         m_k      = 0;
   logic [2:0] m_sel    = '0;
   logic       m_op = 0, m_inv = 0, m_dz = 0;
   int         n_valid  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic step(input logic st, input logic op, input logic [2:0] zt, input logic inv,
                       input logic den, input logic fl, input logic rs);
      int   pre, lat;
      logic e_valid, e_norm, e_iter, e_round, e_load;
      @(negedge clk);
      StartE = st; OpType = op; Ztype = zt; InvalidIn = inv; DenormIn = den;
      FlushE = fl; reset = rs;
      #1;
      pre     = (m_kind == 1) ? 1 : 0;
      lat     = (m_kind == 2) ? 2 : int'(NITER) + 2 + pre;
      e_valid = m_active && (m_k == lat);
      e_norm  = m_active && (m_kind == 1) && (m_k == 1);
      e_iter  = m_active && (m_kind != 2) && (m_k > pre) && (m_k <= pre + int'(NITER));
      e_round = m_active && (m_kind != 2) && (m_k == pre + int'(NITER) + 1);
      e_load  = !m_active && st && !fl && !rs;
      if (m_init) begin
         check_eq("Busy", 32'(Busy), 32'(m_active));
         check_eq("ResultValid", 32'(ResultValid), 32'(e_valid));
         check_eq("NormEn", 32'(NormEn), 32'(e_norm));
         check_eq("IterEn", 32'(IterEn), 32'(e_iter));
         check_eq("RoundEn", 32'(RoundEn), 32'(e_round));
         check_eq("LoadOperands", 32'(LoadOperands), 32'(e_load));
         check_eq("SpecialSel", 32'(SpecialSel), 32'(m_sel));
         check_eq("OpTypeQ", 32'(OpTypeQ), 32'(m_op));
         check_eq("InvalidFlag", 32'(InvalidFlag), 32'(m_inv));
         check_eq("DivZeroFlag", 32'(DivZeroFlag), 32'(m_dz));
         if (e_iter)
            check_eq("IterCount", 32'(IterCount), 32'(m_k - pre - 1));
         else if ((m_active && (m_kind == 2 || m_k <= pre)) || (!m_active && m_clean))
            check_eq("IterCount_zero", 32'(IterCount), 32'd0);
      end
      if (e_valid) n_valid++;
      // Advance the model across the coming rising edge.
      if (rs) begin
         m_init = 1; m_active = 0; m_clean = 1;
         m_sel = '0; m_op = 0; m_inv = 0; m_dz = 0;
      end else if (fl) begin
         m_active = 0;
      end else if (m_active) begin
         if (m_k == lat) m_active = 0;
         else m_k++;
      end else if (st) begin
         m_active = 1; m_k = 1; m_clean = 0;
         m_sel = zt; m_op = op; m_inv = inv; m_dz = (zt == 3'b110) && !op;
         m_kind = (zt != 3'b000 || inv) ? 2 : (den ? 1 : 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 3'b000, 0, 0, 0, 0);
   endtask

   logic [2:0] ztab [7];
   int         v0;

   initial begin
      ztab = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
      step(0, 0, 3'b000, 0, 0, 0, 1);
      step(0, 0, 3'b000, 0, 0, 0, 1);
      idle(2);
      // Normal divide, denormal sqrt, divide-by-zero, invalid sqrt, sqrt of Ztype 110.
      step(1, 0, 3'b000, 0, 0, 0, 0); idle(18);
      step(1, 1, 3'b000, 0, 1, 0, 0); idle(19);
      step(1, 0, 3'b110, 0, 0, 0, 0); idle(4);
      step(1, 1, 3'b001, 1, 0, 0, 0); idle(4);
      step(1, 1, 3'b110, 0, 0, 0, 0); idle(4);
      // Flush at cycle 5 with ignored StartE pulses at 3 and 5, new accept at 6.
      v0 = n_valid;
      step(1, 0, 3'b000, 0, 0, 0, 0); idle(2);
      step(1, 1, 3'b011, 0, 0, 0, 0); idle(1);
      step(1, 1, 3'b011, 0, 0, 1, 0);
      check_eq("flush_no_valid", 32'(n_valid - v0), 32'd0);
      step(1, 1, 3'b010, 0, 0, 0, 0); idle(4);
      // Reset mid-iteration at cycle 8.
      step(1, 0, 3'b000, 0, 0, 0, 0); idle(7);
      v0 = n_valid;
      step(0, 0, 3'b000, 0, 0, 0, 1); idle(20);
      check_eq("reset_no_valid", 32'(n_valid - v0), 32'd0);
      // Flush in DONE keeps that cycle's ResultValid.
      step(1, 0, 3'b010, 0, 0, 0, 0); idle(1);
      step(0, 0, 3'b000, 0, 0, 1, 0); idle(2);
      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              ztab[$urandom_range(0, 6)], $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 99) == 0);
      end
      check_eq("saw_results", 32'(n_valid > 20), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
